// File: rtl/image_write.sv
// image_write: sink for the dual-pixel video stream. Each accepted pair is
// written to the frame memory in BGR byte order. Rows are stored bottom-up,
// as BMP expects. Frame completion and protocol errors are flagged.
//
// Ports
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   VSYNC                 one-cycle start-of-frame pulse
//   HSYNC                 pixel-pair valid strobe
//   DATA_{R,G,B}0         even (left) pixel of the pair
//   DATA_{R,G,B}1         odd (right) pixel of the pair
//   wr_en/addr/data       frame-memory write port, one cycle after acceptance
//   write_done            level, frame fully written
//   frame_err             sticky protocol error, cleared only by reset
//   pair_cnt              pairs accepted in the current frame (saturating)
//
// State | meaning
// IDLE  | after reset, waiting for the first VSYNC; HSYNC ignored
// RECV  | accepting pairs of the current frame
// DONE  | frame complete; HSYNC is an error, VSYNC starts a new frame
//
// The pair count must reach WIDTH*HEIGHT/2, so ADDR_W needs to hold that
// value as well as the highest address.
module image_write #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 18
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [47:0]       wr_data,
  output logic              write_done,
  output logic              frame_err,
  output logic [ADDR_W-1:0] pair_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] HALF_W   = ADDR_W'(WIDTH / 2);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(WIDTH / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] TOP_BASE = ADDR_W'((HEIGHT - 1) * (WIDTH / 2));
  localparam logic [ADDR_W-1:0] TOTAL    = ADDR_W'((WIDTH / 2) * HEIGHT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [47:0]         wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= TOP_BASE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    // VSYNC beats HSYNC in every state: any pair in the same cycle is dropped.
    if (VSYNC) begin
      if (state_q == ST_RECV) err_d = 1'b1;
      state_d = ST_RECV;
      col_d   = '0;
      row_d   = '0;
      base_d  = TOP_BASE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (HSYNC) begin
            wr_en_d   = 1'b1;
            // base holds (HEIGHT-1-row)*WIDTH/2, so no multiplier is needed
            wr_addr_d = base_q + col_q;
            wr_data_d = {DATA_B1, DATA_G1, DATA_R1, DATA_B0, DATA_G0, DATA_R0};
            cnt_d     = (cnt_q == TOTAL) ? cnt_q : cnt_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              if (row_q == LAST_ROW) begin
                state_d = ST_DONE;
              end else begin
                row_d  = row_q + 1'b1;
                base_d = base_q - HALF_W;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          // done rises the cycle after the final write is presented
          done_d = 1'b1;
          if (HSYNC) err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign write_done = done_q;
  assign frame_err  = err_q;
  assign pair_cnt   = cnt_q;

endmodule

// File: tb/tb_image_write.sv
module tb_image_write;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 4;
  localparam int TOTAL = W * H / 2;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          VSYNC, HSYNC;
  logic [7:0]    DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [47:0]   wr_data;
  logic          write_done, frame_err;
  logic [AW-1:0] pair_cnt;

  image_write #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .write_done(write_done), .frame_err(frame_err), .pair_cnt(pair_cnt)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: frame mode (0 idle, 1 receiving, 2 complete), pairs taken
  int          m_mode;
  int          m_k;
  bit          m_err;
  bit          m_done;
  bit          exp_en;
  int          exp_addr;
  logic [47:0] exp_data;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_err = 0; m_done = 0; exp_en = 0;
  endtask

  task automatic model_step(input bit vs, input bit hs, input logic [47:0] px);
    bit done_next;
    done_next = (m_mode == 2) && !vs;
    exp_en = 0;
    if (vs) begin
      if (m_mode == 1) m_err = 1;
      m_mode = 1;
      m_k = 0;
    end else if (hs) begin
      if (m_mode == 1) begin
        exp_en   = 1;
        exp_addr = (H - 1 - m_k / (W / 2)) * (W / 2) + m_k % (W / 2);
        exp_data = px;
        m_k++;
        if (m_k == TOTAL) m_mode = 2;
      end else if (m_mode == 2) begin
        m_err = 1;
      end
    end
    m_done = done_next;
  endtask

  // drive one cycle, advance the model, compare everything
  task automatic cycle(input bit vs, input bit hs, input logic [47:0] px);
    VSYNC = vs; HSYNC = hs;
    {DATA_B1, DATA_G1, DATA_R1, DATA_B0, DATA_G0, DATA_R0} = px;
    @(posedge HCLK); #1;
    cyc++;
    model_step(vs, hs, px);
    chk("wr_en", wr_en, exp_en);
    if (exp_en) begin
      chk("wr_addr", wr_addr, exp_addr);
      chk("wr_data", wr_data, exp_data);
    end
    chk("write_done", write_done, m_done);
    chk("frame_err", frame_err, m_err);
    chk("pair_cnt", pair_cnt, m_k);
    VSYNC = 0; HSYNC = 0;
  endtask

  function automatic logic [47:0] pix(input logic [7:0] r0);
    return {8'h60, 8'h50, 8'h40, 8'h30, 8'h20, r0};
  endfunction

  task automatic do_reset();
    HRESETn = 0; VSYNC = 0; HSYNC = 0;
    @(posedge HCLK); #2;
    HRESETn = 1;
    model_reset();
  endtask

  typedef struct {
    bit          vs;
    bit          hs;
    logic [7:0]  r0;
    bit          en;
    logic [3:0]  addr;
    logic [47:0] data;
    bit          done;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int prev;
    tbl[0] = '{1, 0, 8'h00, 0, 4'd0, 48'h0,            0, 4'd0};
    tbl[1] = '{0, 1, 8'h10, 1, 4'd2, 48'h605040302010, 0, 4'd1};
    tbl[2] = '{0, 1, 8'h11, 1, 4'd3, 48'h605040302011, 0, 4'd2};
    tbl[3] = '{0, 1, 8'h12, 1, 4'd0, 48'h605040302012, 0, 4'd3};
    tbl[4] = '{0, 1, 8'h13, 1, 4'd1, 48'h605040302013, 0, 4'd4};
    tbl[5] = '{0, 0, 8'h00, 0, 4'd0, 48'h0,            1, 4'd4};
    tbl[6] = '{0, 0, 8'h00, 0, 4'd0, 48'h0,            1, 4'd4};

    HRESETn = 0; VSYNC = 0; HSYNC = 0;
    {DATA_B1, DATA_G1, DATA_R1, DATA_B0, DATA_G0, DATA_R0} = '0;
    model_reset();
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done", write_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cnt", pair_cnt, 0);
    @(posedge HCLK); #2;
    HRESETn = 1;

    // IDLE ignores HSYNC
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, pix(8'(i)));
      cycle(0, 0, '0);
    end

    // full frame from the vector table
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].vs, tbl[i].hs, pix(tbl[i].r0));
      chk("tbl_wr_en", wr_en, tbl[i].en);
      if (tbl[i].en) begin
        chk("tbl_addr", wr_addr, tbl[i].addr);
        chk("tbl_data", wr_data, tbl[i].data);
      end
      chk("tbl_done", write_done, tbl[i].done);
      chk("tbl_cnt", pair_cnt, tbl[i].cnt);
    end

    // gapped stream: one write every 4 cycles
    prev = -1;
    cycle(1, 0, '0);
    for (int k = 0; k < TOTAL; k++) begin
      for (int g = 0; g < 4; g++) begin
        cycle(0, g == 0, pix(8'h10 + 8'(k)));
        if (wr_en) begin
          if (prev >= 0) chk("gap_spacing", cyc - prev, 4);
          prev = cyc;
        end
      end
    end
    chk("gap_done", write_done, 1);
    chk("gap_err", frame_err, 0);

    // early VSYNC restarts the frame and flags an error
    cycle(1, 0, '0);
    for (int k = 0; k < 3; k++) cycle(0, 1, pix(8'h70 + 8'(k)));
    cycle(1, 0, '0);
    for (int k = 0; k < 4; k++) cycle(0, 1, pix(8'h80 + 8'(k)));
    cycle(0, 0, '0);
    chk("early_err", frame_err, 1);
    chk("early_done", write_done, 1);
    chk("early_cnt", pair_cnt, 4);

    // VSYNC+HSYNC collision, then HSYNC while complete
    do_reset();
    cycle(1, 1, pix(8'hAA));
    chk("coll_wr_en", wr_en, 0);
    chk("coll_cnt", pair_cnt, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, pix(8'h90 + 8'(k)));
    cycle(0, 0, '0);
    chk("pre_extra_err", frame_err, 0);
    cycle(0, 1, pix(8'hBB));
    chk("extra_wr_en", wr_en, 0);
    chk("extra_err", frame_err, 1);
    chk("extra_done", write_done, 1);

    // asynchronous reset while a write is presented
    do_reset();
    cycle(1, 0, '0);
    cycle(0, 1, pix(8'h01));
    cycle(0, 1, pix(8'h02));
    chk("pre_rst_wr_en", wr_en, 1);
    #2 HRESETn = 0;
    #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_done", write_done, 0);
    chk("async_cnt", pair_cnt, 0);
    chk("async_addr", wr_addr, 0);
    @(posedge HCLK); #2;
    HRESETn = 1;
    model_reset();
    cycle(1, 0, '0);
    for (int k = 0; k < 4; k++) cycle(0, 1, pix(8'hC0 + 8'(k)));
    cycle(0, 0, '0);
    chk("post_rst_done", write_done, 1);
    chk("post_rst_err", frame_err, 0);

    // random traffic against the model
    do_reset();
    cycle(1, 0, '0);
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            {16'($urandom), 32'($urandom)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
